// File: rtl/ec_dec_renorm_pkg.sv
// Shared constants and state encoding for the arithmetic-decoder
// renormalization/refill block.
package ec_dec_renorm_pkg;

    localparam int DATA_16    = 16;   // rng width
    localparam int WIN_SIZE   = 32;   // dif window width
    localparam int CNT_SIZE   = 16;   // signed bit-count width
    localparam int D_SIZE     = 4;    // normalization shift width
    localparam int WIN_OFFSET = 24;   // window offset used to place a new byte

    // Bit count forced once the stream is exhausted, large enough that no
    // further refill is ever requested.
    localparam logic [CNT_SIZE-1:0] LOTS_OF_BITS = 16'h4000;

    localparam logic [DATA_16-1:0]         INIT_RNG = 16'h8000;
    localparam logic signed [CNT_SIZE-1:0] INIT_CNT = -16'sd15;
    localparam logic [WIN_SIZE-1:0]        INIT_DIF = {1'b0, {(WIN_SIZE-1){1'b1}}};

    // Free space at the bottom of the window is WIN_SLACK - cnt.
    localparam logic signed [CNT_SIZE-1:0] WIN_SLACK = CNT_SIZE'(WIN_SIZE - WIN_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NORM   = 2'd1,
        ST_REFILL = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ec_dec_renorm_leading_zero.sv
// Leading-zero count of the range register; gives the normalization
// shift d. An all-zero input yields 0 (never presented in practice).
module leading_zero #(
    parameter int RANGE_SIZE = 16,
    parameter int D_SIZE_LZC = 4
) (
    input  logic [RANGE_SIZE-1:0] i_rng,
    output logic [D_SIZE_LZC-1:0] o_d
);

    // Scan from LSB upward so the highest set bit writes last and wins.
    always_comb begin
        o_d = '0;
        for (int i = 0; i < RANGE_SIZE; i++) begin
            if (i_rng[i]) begin
                o_d = D_SIZE_LZC'(RANGE_SIZE - 1 - i);
            end
        end
    end

endmodule

// File: rtl/ec_dec_renorm.sv
// Arithmetic-decoder renormalization: shifts rng/dif up after each symbol,
// then refills the dif window one compressed byte per cycle until the
// window has no room for another byte (or the stream has ended).
//
// Handshakes: every interface transfers on a cycle where its valid and
// ready are both high at the clock edge. in_ready is high only in IDLE,
// out_valid only in DONE, and byte_ready only in REFILL while a byte fits
// and the stream has not ended; valid never depends on ready.
module ec_dec_renorm
    import ec_dec_renorm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                norm_valid,
    output logic                in_ready,
    input  logic [WIN_SIZE-1:0] in_dif,
    input  logic [DATA_16-1:0]  in_rng,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                byte_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIN_SIZE-1:0] out_dif,
    output logic [DATA_16-1:0]  out_rng,
    output logic [CNT_SIZE-1:0] out_cnt,
    output logic [1:0]          dbg_state
);

    state_t                      r_state;
    logic [WIN_SIZE-1:0]         r_dif;
    logic [DATA_16-1:0]          r_rng;
    logic signed [CNT_SIZE-1:0]  r_cnt;
    logic                        r_eos;

    logic [WIN_SIZE-1:0]         r_out_dif;
    logic [DATA_16-1:0]          r_out_rng;
    logic signed [CNT_SIZE-1:0]  r_out_cnt;

    logic [D_SIZE-1:0]           w_d;
    logic [WIN_SIZE-1:0]         w_dif_inc;
    logic [WIN_SIZE-1:0]         w_dif_norm;
    logic [DATA_16-1:0]          w_rng_norm;
    logic signed [CNT_SIZE-1:0]  w_cnt_norm;
    logic signed [CNT_SIZE-1:0]  w_s;
    logic [WIN_SIZE-1:0]         w_byte_ext;
    logic [WIN_SIZE-1:0]         w_dif_byte;
    logic signed [CNT_SIZE-1:0]  w_cnt_byte;
    logic signed [CNT_SIZE-1:0]  w_s_byte;
    logic                        w_s_neg;
    logic                        w_s_byte_neg;
    logic                        w_take_ok;

    leading_zero #(
        .RANGE_SIZE (DATA_16),
        .D_SIZE_LZC (D_SIZE)
    ) u_lzc (
        .i_rng (r_rng),
        .o_d   (w_d)
    );

    // Normalization: dif shifts in ones from the bottom, hence the +1/-1.
    assign w_dif_inc  = r_dif + WIN_SIZE'(1);
    assign w_dif_norm = (w_dif_inc << w_d) - WIN_SIZE'(1);
    assign w_rng_norm = r_rng << w_d;
    assign w_cnt_norm = r_cnt - $signed({{(CNT_SIZE-D_SIZE){1'b0}}, w_d});

    // Refill: a byte lands s bits above the window bottom. s never exceeds
    // WIN_SLACK + 15 while cnt stays >= -15, so five shift bits suffice.
    assign w_s          = WIN_SLACK - r_cnt;
    assign w_s_neg      = (w_s < 0);
    assign w_byte_ext   = {{(WIN_SIZE-8){1'b0}}, byte_data};
    assign w_dif_byte   = r_dif ^ (w_byte_ext << w_s[4:0]);
    assign w_cnt_byte   = r_cnt + 16'sd8;
    assign w_s_byte     = WIN_SLACK - w_cnt_byte;
    assign w_s_byte_neg = (w_s_byte < 0);

    assign w_take_ok  = (r_state == ST_REFILL) && !w_s_neg && !r_eos;
    assign byte_ready = w_take_ok && byte_valid;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_dif   = r_out_dif;
    assign out_rng   = r_out_rng;
    assign out_cnt   = r_out_cnt;
    assign dbg_state = r_state;

    // Control FSM and decoder state; output registers load on entry to DONE
    // and otherwise hold their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dif     <= '0;
            r_rng     <= '0;
            r_cnt     <= '0;
            r_eos     <= 1'b0;
            r_out_dif <= '0;
            r_out_rng <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init) begin
                        r_dif   <= INIT_DIF;
                        r_rng   <= INIT_RNG;
                        r_cnt   <= INIT_CNT;
                        r_eos   <= 1'b0;
                        r_state <= ST_REFILL;
                    end else if (norm_valid) begin
                        r_dif   <= in_dif;
                        r_rng   <= in_rng;
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_dif <= w_dif_norm;
                    r_rng <= w_rng_norm;
                    r_cnt <= w_cnt_norm;
                    if (w_cnt_norm < 0) begin
                        r_state <= ST_REFILL;
                    end else begin
                        r_out_dif <= w_dif_norm;
                        r_out_rng <= w_rng_norm;
                        r_out_cnt <= w_cnt_norm;
                        r_state   <= ST_DONE;
                    end
                end
                ST_REFILL: begin
                    if (w_s_neg) begin
                        r_out_dif <= r_dif;
                        r_out_rng <= r_rng;
                        r_out_cnt <= r_cnt;
                        r_state   <= ST_DONE;
                    end else if (r_eos) begin
                        r_cnt     <= LOTS_OF_BITS;
                        r_out_dif <= r_dif;
                        r_out_rng <= r_rng;
                        r_out_cnt <= LOTS_OF_BITS;
                        r_state   <= ST_DONE;
                    end else if (byte_valid) begin
                        r_dif <= w_dif_byte;
                        r_cnt <= w_cnt_byte;
                        if (byte_last) begin
                            r_eos <= 1'b1;
                        end
                        // Finish right away when the byte just taken filled
                        // the window, saving the re-check cycle.
                        if (w_s_byte_neg) begin
                            r_out_dif <= w_dif_byte;
                            r_out_rng <= r_rng;
                            r_out_cnt <= w_cnt_byte;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_dec_renorm.sv
// Directed bench for ec_dec_renorm: a spec-level model predicts each
// transaction's result, consumed byte count and latency; a per-cycle
// compare process checks outputs against the model's expected queue.
module tb_ec_dec_renorm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic        norm_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_dif = '0;
    logic [15:0] in_rng = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_dif;
    logic [15:0] out_rng;
    logic [15:0] out_cnt;
    logic [1:0]  dbg_state;

    ec_dec_renorm dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .norm_valid (norm_valid),
        .in_ready   (in_ready),
        .in_dif     (in_dif),
        .in_rng     (in_rng),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dif    (out_dif),
        .out_rng    (out_rng),
        .out_cnt    (out_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  src_q[$];   // bytes presented to the DUT {last, data}
    logic [8:0]  mdl_q[$];   // same stream, consumed by the model
    logic [63:0] exp_q[$];   // expected {dif, rng, cnt}
    bit          src_stall = 1'b0;
    bit          took = 1'b0;
    bit          blk_byte = 1'b0;
    int          n_took = 0;

    // model state
    logic [31:0] m_dif = '0;
    logic [15:0] m_rng = '0;
    int          m_cnt = 0;
    bit          m_eos = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] data, input bit last);
        src_q.push_back({last, data});
        mdl_q.push_back({last, data});
    endtask

    // Spec-level model of one accepted transaction. Latency counts clock
    // edges from the accept edge up to the one that raises out_valid.
    task automatic model_txn(input bit is_init, input logic [31:0] dif, input logic [15:0] rng,
                             output int nb, output int lat);
        int d;
        int s;
        logic [31:0] t;
        logic [8:0]  b;
        bit          do_refill;
        nb = 0;
        if (is_init) begin
            m_dif = 32'h7FFF_FFFF;
            m_rng = 16'h8000;
            m_cnt = -15;
            m_eos = 1'b0;
            lat = 1;
            do_refill = 1'b1;
        end else begin
            d = 0;
            while (d < 15 && rng[15-d] == 1'b0) d++;
            t = dif + 32'd1;
            t = t << d;
            m_dif = t - 32'd1;
            m_rng = rng << d;
            m_cnt = m_cnt - d;
            lat = 2;
            do_refill = (m_cnt < 0);
        end
        while (do_refill) begin
            s = 8 - m_cnt;
            if (s < 0) break;
            if (m_eos) begin
                m_cnt = 16384;
                lat++;
                break;
            end
            if (mdl_q.size() == 0) begin
                check("model_stream_empty", 64'd1, 64'd0);
                break;
            end
            b = mdl_q.pop_front();
            m_dif = m_dif ^ ({24'd0, b[7:0]} << s);
            m_cnt = m_cnt + 8;
            nb++;
            lat++;
            if (b[8]) m_eos = 1'b1;
        end
        exp_q.push_back({m_dif, m_rng, 16'(m_cnt)});
    endtask

    // ---------------- byte source driver ----------------
    always @(posedge clk) begin
        #2;
        if (took) begin
            n_took++;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        byte_valid = (src_q.size() > 0) && !src_stall;
        byte_data  = (src_q.size() > 0) ? src_q[0][7:0] : 8'h00;
        byte_last  = (src_q.size() > 0) ? src_q[0][8] : 1'b0;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        took = !reset && byte_valid && byte_ready;
        if (!reset) begin
            check("byte_ready_implies_valid", {63'd0, byte_ready & ~byte_valid}, 64'd0);
            if (blk_byte) check("no_byte_after_eos", {63'd0, byte_ready}, 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    check("out_dif", {32'd0, out_dif}, {32'd0, exp_q[0][63:32]});
                    check("out_rng", {48'd0, out_rng}, {48'd0, exp_q[0][31:16]});
                    check("out_cnt", {48'd0, out_cnt}, {48'd0, exp_q[0][15:0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- transaction driver ----------------
    task automatic run_txn(input bit is_init, input logic [31:0] dif, input logic [15:0] rng,
                           input int hold, input bit chk_lat, input logic [63:0] pin);
        int nb;
        int lat_exp;
        int lat;
        int t0;
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        @(posedge clk);
        #1;
        if (is_init) blk_byte = 1'b0;
        t0 = n_took;
        model_txn(is_init, dif, rng, nb, lat_exp);
        init       = is_init;
        norm_valid = !is_init;
        in_dif     = dif;
        in_rng     = rng;
        @(posedge clk);
        #1;
        init       = 1'b0;
        norm_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            exp_q.delete();
            return;
        end
        if (chk_lat) check("latency", 64'(lat), 64'(lat_exp));
        check("pin_dif", {32'd0, out_dif}, {32'd0, pin[63:32]});
        check("pin_rng", {48'd0, out_rng}, {48'd0, pin[31:16]});
        check("pin_cnt", {48'd0, out_cnt}, {48'd0, pin[15:0]});
        repeat (hold + 1) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bytes_consumed", 64'(n_took - t0), 64'(nb));
        check("in_ready_after_done", {63'd0, in_ready}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_out_dif", {32'd0, out_dif}, 64'd0);
        check("rst_out_rng", {48'd0, out_rng}, 64'd0);
        check("rst_out_cnt", {48'd0, out_cnt}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);

        // init with three bytes
        push_byte(8'hA5, 1'b0); push_byte(8'h3C, 1'b0); push_byte(8'h00, 1'b0);
        run_txn(1'b1, 32'h0, 16'h0, 0, 1'b1, {32'h2D61FFFF, 16'h8000, 16'd9});

        // plain norm, d=8, downstream holds off 3 cycles
        run_txn(1'b0, 32'h12345678, 16'h00F0, 3, 1'b1, {32'h345678FF, 16'hF000, 16'd1});

        // re-init, then norm that needs two refill bytes
        push_byte(8'hA5, 1'b0); push_byte(8'h3C, 1'b0); push_byte(8'h00, 1'b0);
        run_txn(1'b1, 32'h0, 16'h0, 0, 1'b1, {32'h2D61FFFF, 16'h8000, 16'd9});
        push_byte(8'hFF, 1'b0); push_byte(8'h01, 1'b0);
        run_txn(1'b0, 32'h0000FFFF, 16'h0001, 0, 1'b1, {32'h7FC03FBF, 16'h8000, 16'd10});

        // d=7 brings cnt to 3, then d=0 passes state through
        run_txn(1'b0, 32'h00001000, 16'h0100, 1, 1'b1, {32'h0008007F, 16'h8000, 16'd3});
        run_txn(1'b0, 32'hDEADBEEF, 16'h8001, 0, 1'b1, {32'hDEADBEEF, 16'h8001, 16'd3});

        // byte source stalled during refill
        @(posedge clk);
        #1;
        src_stall = 1'b1;
        push_byte(8'hA5, 1'b0); push_byte(8'h3C, 1'b0); push_byte(8'h00, 1'b0);
        fork
            run_txn(1'b1, 32'h0, 16'h0, 0, 1'b0, {32'h2D61FFFF, 16'h8000, 16'd9});
            begin
                repeat (7) begin
                    @(negedge clk);
                    check("stall_byte_ready", {63'd0, byte_ready}, 64'd0);
                    check("stall_out_valid", {63'd0, out_valid}, 64'd0);
                end
                src_stall = 1'b0;
            end
        join

        // end of stream: single last byte
        push_byte(8'h80, 1'b1);
        run_txn(1'b1, 32'h0, 16'h0, 0, 1'b1, {32'h3FFFFFFF, 16'h8000, 16'h4000});
        blk_byte = 1'b1;
        push_byte(8'h55, 1'b0);
        run_txn(1'b0, 32'h00000001, 16'h0001, 0, 1'b1, {32'h0000FFFF, 16'h8000, 16'h3FF1});
        @(posedge clk);
        #1;
        src_q.delete();
        mdl_q.delete();
        blk_byte = 1'b0;
        repeat (2) @(posedge clk);

        // reset while stalled in refill
        #1;
        src_stall = 1'b1;
        push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0);
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        check("mid_rst_out_dif", {32'd0, out_dif}, 64'd0);
        check("mid_rst_out_rng", {48'd0, out_rng}, 64'd0);
        check("mid_rst_out_cnt", {48'd0, out_cnt}, 64'd0);
        @(posedge clk);
        #1;
        src_q.delete();
        mdl_q.delete();
        src_stall = 1'b0;
        m_dif = '0;
        m_rng = '0;
        m_cnt = 0;
        m_eos = 1'b0;
        repeat (2) @(posedge clk);

        // normal operation after reset
        push_byte(8'hA5, 1'b0); push_byte(8'h3C, 1'b0); push_byte(8'h00, 1'b0);
        run_txn(1'b1, 32'h0, 16'h0, 0, 1'b1, {32'h2D61FFFF, 16'h8000, 16'd9});

        repeat (4) @(posedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
